// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the count sequencer and its counter datapath.
package count_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10
    } state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// Control/status bundle between task-level control logic and the count sequencer.
interface count_sequencer_if
    import count_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             stop;
    logic             pause;
    logic             periodic;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, pause, periodic, term_val,
        input  count, busy, done
    );

    modport slave (
        input  start, stop, pause, periodic, term_val,
        output count, busy, done
    );

endinterface

// File: rtl/count_sequencer_up_counter_w.sv
// WIDTH-bit up-counter register; synchronous clear takes priority over enable.
module up_counter_w #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Sequences an up-counter: clear, run to a latched terminal value, then stop or wrap.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    count_sequencer_if.slave  ctrl
);

    state_t           state;
    logic [WIDTH-1:0] term;
    logic             mode;
    logic [WIDTH-1:0] cnt;
    logic             clr;
    logic             en;
    logic             busy;
    logic             done;

    // Counter controls follow the current state so the counter moves on the same edge as the FSM.
    always_comb begin
        clr = 1'b0;
        en  = 1'b0;
        case (state)
            CLEAR: clr = 1'b1;
            RUN: begin
                if (!ctrl.stop && !ctrl.pause) begin
                    if (cnt == term) begin
                        clr = mode;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            term  <= '0;
            mode  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl.start && !ctrl.stop) begin
                        term  <= ctrl.term_val;
                        mode  <= ctrl.periodic;
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ctrl.stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (ctrl.stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!ctrl.pause && cnt == term) begin
                        done <= 1'b1;
                        if (!mode) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    up_counter_w #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .count (cnt)
    );

    assign ctrl.count = cnt;
    assign ctrl.busy  = busy;
    assign ctrl.done  = done;

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that sequences a WIDTH-bit up-counter datapath. It clears the counter, runs it to a programmable terminal value, and either stops (one-shot) or wraps (periodic).
- Exposes a start/stop/pause control interface plus busy/done status.
- Sits between the task-level control logic and the binary counter it owns.

Parameters:
WIDTH, 4, counter and terminal-value width in bits

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a sequence; sampled only in IDLE
stop  input  1  abort the sequence; highest priority after reset
pause  input  1  while high in RUN, counter holds
periodic  input  1  mode select, latched at start: 1=periodic, 0=one-shot
term_val  input  WIDTH  terminal count, latched at start
count  output  WIDTH  current counter value
busy  output  1  high in CLEAR and RUN
done  output  1  one-cycle registered pulse per completed count sequence

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, busy=0, done=0, latched term/mode=0. This applies immediately, including mid-sequence.
- All other updates occur on the rising edge of clk.
- States: IDLE, CLEAR, RUN.
- IDLE:
  - busy=0.
  - start=1 and stop=0: latch term_val and periodic, then go to CLEAR.
  - start=1 and stop=1 in the same cycle: stay IDLE.
  - count holds its last value.
- CLEAR:
  - Exactly one cycle. busy=1.
  - The counter clears, so count=0 in the next cycle. pause is ignored.
  - Next state is RUN, or IDLE if stop=1.
- RUN:
  - stop=1: next state IDLE, count held, done=0.
  - pause=1: count held, no done, state held. This applies even when count==term.
  - pause=0 and count!=term: count increments by 1.
  - pause=0, count==term, one-shot: next state IDLE, count held at term, done=1 for the next cycle.
  - pause=0, count==term, periodic: count goes to 0 next cycle, state stays RUN, done=1 for that cycle. The period is term+1 cycles.
- Timing from start asserted in cycle 0:
  - cycle 1: CLEAR, busy=1.
  - cycle 2: RUN, count=0.
  - cycle 2+k: count=k, assuming no pause.
  - One-shot: done=1 and busy=0 in cycle term+3.
- done is registered and never high for two consecutive cycles unless term=0 in periodic mode. In that case done is continuously high and count stays 0.
- Width rule: count never exceeds the latched term, so no overflow occurs. term=2^WIDTH-1 reaches its maximum without wrapping.
- start while busy: ignored. term_val and periodic changes while busy: ignored.

Decomposition:
- Shared package:
  - state encoding IDLE=2'b00, CLEAR=2'b01, RUN=2'b10 (2'b11 unused; it must return to IDLE).
  - default WIDTH constant.
- Sub-module up_counter_w: WIDTH-bit register with clk, active-low async reset, synchronous clr (priority) and enable, output count.
- The FSM, term/mode latches and done register live in count_sequencer.

Test Plan:
1. Async reset: assert reset=0 mid-RUN at count=5, away from the clock edge. Required: count=0, busy=0, done=0 immediately; after release, state is IDLE.
2. One-shot, term=3: start pulse in cycle 0. Required: busy=1 in cycles 1-5; count=0,1,2,3 in cycles 2-5; done=1 and busy=0 in cycle 6; count stays at 3.
3. Periodic, term=2: required count sequence 0,1,2,0,1,2,...; done=1 in each cycle where count returns to 0 after 2 (cycles 5, 8, 11); busy stays 1 until stop. Then stop=1 gives busy=0 the next cycle with count held.
4. Pause: one-shot term=4, pause=1 for 3 cycles at count=2, then 3 cycles at count=4. Required: count holds during each pause; done is delayed until the cycle after the second pause releases.
5. Stop and start conflicts:
   - stop during CLEAR: returns to IDLE.
   - start and stop together in IDLE: stays IDLE.
   - start while busy: no effect.
   - term_val changed mid-RUN: original term still used.
6. Boundary terms:
   - one-shot term=0: done=1 in cycle 3.
   - term=15 (WIDTH=4): reaches 15 with no wrap in one-shot mode.
   - periodic term=0: done held high, count stays 0.
